clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//   Multi-channel, run-time reprogrammable clock-enable generator. Each channel runs a
//   phase-accumulator NCO on the single fabric clock and emits one-cycle enable strobes
//   at f_clkin*inc/2^ACC_W. Replaces fixed-ratio PLL outputs for slow domains (pixel/LCD
//   6.25 MHz, audio, timers). Adds a PLL-style lock indication and a config handshake.
// PARAMETERS
//   NUM_CH       4          number of enable channels (1..8)
//   ACC_W        32         accumulator / increment width in bits (8..32)
//   DEFAULT_INC  32'h2000_0000  reset increment, all channels (50 MHz -> 6.25 MHz, /8)
//   LOCK_CYCLES  16         cycles lock stays low after reset or after any reconfig (>=1)
// PORTS
//   clkin       in   1              fabric clock; all logic on its rising edge
//   reset       in   1              synchronous, active-high
//   en          in   NUM_CH         per-channel run enable (ENCLKn equivalent)
//   cfg_valid   in   1              config request
//   cfg_ready   out  1              config accepted when cfg_valid & cfg_ready
//   cfg_ch      in   3              target channel index
//   cfg_inc     in   ACC_W          new increment for cfg_ch
//   cfg_phase   in   ACC_W          accumulator load value (initial phase) for cfg_ch
//   cfg_err     out  1              1-cycle pulse: accepted request had cfg_ch >= NUM_CH
//   lock        out  1              high when all channels are stable and strobes are live
//   ce_out      out  NUM_CH         per-channel one-cycle enable strobes
// BEHAVIOUR
//   Reset: acc[c]=0, inc[c]=DEFAULT_INC, lock=0, ce_out=0, cfg_ready=0, cfg_err=0,
//     state=LOCKING, lock_cnt=LOCK_CYCLES-1. Reset mid-operation aborts everything.
//   NCO, per channel, every cycle with en[c]=1: {carry,acc[c]} <= acc[c]+inc[c] (ACC_W+1
//     bit sum, wraps mod 2^ACC_W). ce_out[c] <= carry & lock_q, where lock_q is the
//     registered lock. Strobe latency: 1 cycle after the wrap-producing edge.
//   en[c]=0: acc[c] holds, ce_out[c]=0 next cycle; resuming continues from held phase.
//   inc[c]=0: never strobes. inc[c]=2^ACC_W-1: strobes every cycle except one per 2^ACC_W.
//   Accumulators run during LOCKING; only ce_out is suppressed (phase is preserved).
//   FSM states:
//     LOCKING: lock=0, cfg_ready=0; lock_cnt decrements each cycle; at 0 -> LOCKED.
//     LOCKED : lock=1, cfg_ready=1. On cfg_valid & cfg_ready -> APPLY.
//     APPLY  : one cycle. If cfg_ch < NUM_CH: inc[cfg_ch]<=cfg_inc, acc[cfg_ch]<=cfg_phase
//              (overrides that channel's NCO update this cycle), lock_cnt<=LOCK_CYCLES-1,
//              -> LOCKING. Else: cfg_err=1 for this cycle, no register change, -> LOCKED.
//   cfg fields are captured on the accept edge; later changes on cfg_* are ignored.
//   lock and cfg_ready fall on the cycle after accept (APPLY); cfg_valid held high while
//     not ready is simply waited on, never dropped.
// STRUCTURE
//   Package clk_enable_pkg: FSM state enum (LOCKING, LOCKED, APPLY), ACC_W default,
//     function inc_for(f_in_hz, f_out_hz) returning the ACC_W-bit increment.
//   Sub-module clk_enable_nco (one channel): acc/inc regs, load port, en, carry out;
//     instantiated NUM_CH times by a generate loop. FSM + lock counter live at top.
// TESTING  (NUM_CH=4, ACC_W=32, LOCK_CYCLES=16)
//   1 reset 3 cycles, en=4'hF -> lock rises 16 cycles after reset drop; ce_out[0..3] then
//     strobe every 8 cycles, all in phase; no strobe while lock=0.
//   2 cfg ch1 inc=32'h4000_0000 phase=0 -> lock low 16 cycles, then ce_out[1] every 4
//     cycles; ch0/2/3 keep their pre-config phase (strobe spacing still 8 across the gap).
//   3 cfg ch2 inc=0 -> ce_out[2] never asserts over 1000 cycles; ch2 phase load via
//     cfg_phase=32'hE000_0000, inc=32'h2000_0000 -> first ch2 strobe 1 cycle after carry.
//   4 cfg_ch=5 -> cfg_err pulses exactly 1 cycle, lock stays high (dropping 1 cycle max
//     not allowed), all channels unchanged.
//   5 en[3]=0 for 5 cycles mid-period then 1 -> ce_out[3] delayed exactly 5 cycles.
//   6 assert reset during LOCKING after a cfg -> all incs back to DEFAULT_INC, full 16-cycle relock.

Source files
------------

// File: rtl/clk_enable_pkg.sv
// rtl/clk_enable_pkg.sv - shared types and helpers for the clock-enable generator
package clk_enable_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    APPLY   = 2'd2
  } state_e;

  // Increment giving f_out_hz strobes from an f_in_hz clock: f_out * 2^ACC_W / f_in.
  function automatic logic [ACC_W_DEF-1:0] inc_for(input longint unsigned f_in_hz,
                                                  input longint unsigned f_out_hz);
    longint unsigned q;
    q = (f_out_hz << ACC_W_DEF) / f_in_hz;
    return q[ACC_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/clk_enable_nco.sv
// rtl/clk_enable_nco.sv - one phase-accumulator channel with increment/phase load port
module clk_enable_nco
  import clk_enable_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(32'h2000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W:0]   sum;

  // A load replaces this cycle's accumulate, so it never produces a carry.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d = acc_q;
    inc_d = inc_q;
    carry = 1'b0;
    if (load) begin
      acc_d = load_phase;
      inc_d = load_inc;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
      carry = sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      inc_q <= DEFAULT_INC;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel NCO clock-enable generator with lock and config handshake
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(32'h2000_0000),
  parameter int               LOCK_CYCLES = 16
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic              lock,
  output logic [NUM_CH-1:0] ce_out
);

  localparam int             CNT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOCK_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         ch_q, ch_d;
  logic [ACC_W-1:0]   inc_q, inc_d;
  logic [ACC_W-1:0]   phase_q, phase_d;
  logic [NUM_CH-1:0]  ce_q, ce_d;
  logic [NUM_CH-1:0]  carry;
  logic [NUM_CH-1:0]  load;
  logic               accept;
  logic               ch_ok;

  assign accept = cfg_valid & cfg_ready;
  assign ch_ok  = int'(ch_q) < NUM_CH;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= LOCKING;
      cnt_q   <= CNT_RELOAD;
      ch_q    <= '0;
      inc_q   <= '0;
      phase_q <= '0;
      ce_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      ce_q    <= ce_d;
    end
  end

  // Request fields are frozen on the accept edge; APPLY works from the copies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    inc_d   = inc_q;
    phase_d = phase_q;
    if (accept) begin
      ch_d    = cfg_ch;
      inc_d   = cfg_inc;
      phase_d = cfg_phase;
    end
    case (state_q)
      LOCKING: begin
        if (cnt_q == '0) state_d = LOCKED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      LOCKED: begin
        if (cfg_valid) state_d = APPLY;
      end
      APPLY: begin
        if (ch_ok) begin
          state_d = LOCKING;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = LOCKING;
    endcase
  end

  // A rejected request leaves the channels untouched, so lock stays up through APPLY.
  always_comb begin
    lock      = 1'b0;
    cfg_ready = 1'b0;
    cfg_err   = 1'b0;
    case (state_q)
      LOCKED: begin
        lock      = 1'b1;
        cfg_ready = 1'b1;
      end
      APPLY: begin
        lock    = ~ch_ok;
        cfg_err = ~ch_ok;
      end
      default: ;
    endcase
  end

  assign ce_d   = carry & {NUM_CH{lock}};
  assign ce_out = ce_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load[c] = (state_q == APPLY) && ch_ok && (ch_q == 3'(c));

    clk_enable_nco #(
      .ACC_W      (ACC_W),
      .DEFAULT_INC(DEFAULT_INC)
    ) u_nco (
      .clk       (clkin),
      .reset     (reset),
      .en        (en[c]),
      .load      (load[c]),
      .load_inc  (inc_q),
      .load_phase(phase_q),
      .carry     (carry[c])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - self-checking bench for clk_enable_gen
module tb_clk_enable_gen;
  import clk_enable_pkg::*;

  localparam int          NUM_CH      = 4;
  localparam int          LOCK_CYCLES = 16;
  localparam logic [31:0] DEF_INC     = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  en = 4'hF;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_ch = 3'd0;
  logic [31:0] cfg_inc = 32'd0;
  logic [31:0] cfg_phase = 32'd0;
  logic        cfg_err;
  logic        lock;
  logic [3:0]  ce_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (32),
    .DEFAULT_INC(DEF_INC),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clkin    (clk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .lock     (lock),
    .ce_out   (ce_out)
  );

  // Reference: phase as plain 33-bit sums, lock as "cycles still to wait", pending request flag.
  logic [31:0] m_acc [4];
  logic [31:0] m_inc [4];
  logic [3:0]  m_ce = 4'h0;
  logic        m_lock = 1'b0, m_ready = 1'b0, m_err = 1'b0, m_pend = 1'b0;
  int          m_pch = 0, m_wait = 0;
  logic [31:0] m_pinc = 0, m_pphase = 0;

  initial begin
    logic [32:0] sum;
    logic        lock_now;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_acc[c] = 32'd0;
          m_inc[c] = DEF_INC;
        end
        m_ce = 4'h0; m_lock = 1'b0; m_ready = 1'b0; m_err = 1'b0;
        m_pend = 1'b0; m_wait = LOCK_CYCLES;
      end else begin
        lock_now = m_lock;
        for (int c = 0; c < NUM_CH; c++) begin
          if (m_pend && m_pch == c) begin
            m_acc[c] = m_pphase;
            m_inc[c] = m_pinc;
            m_ce[c]  = 1'b0;
          end else if (en[c]) begin
            sum      = {1'b0, m_acc[c]} + {1'b0, m_inc[c]};
            m_ce[c]  = sum[32] & lock_now;
            m_acc[c] = sum[31:0];
          end else begin
            m_ce[c] = 1'b0;
          end
        end
        m_err = 1'b0;
        if (cfg_valid && m_ready) begin
          m_pend   = 1'b1;
          m_pch    = int'(cfg_ch);
          m_pinc   = cfg_inc;
          m_pphase = cfg_phase;
          m_ready  = 1'b0;
          m_lock   = (m_pch >= NUM_CH);
          m_err    = (m_pch >= NUM_CH);
        end else if (m_pend) begin
          m_pend = 1'b0;
          if (m_pch < NUM_CH) begin
            m_wait = LOCK_CYCLES;
            m_lock = 1'b0;
          end else begin
            m_lock  = 1'b1;
            m_ready = 1'b1;
          end
        end else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            m_lock  = 1'b1;
            m_ready = 1'b1;
          end
        end
      end
    end
  end

  function automatic int now_cyc();
    return int'($time / 10);
  endfunction

  // Raises a request, holds it until taken, and returns at the APPLY-cycle negedge.
  task automatic send_cfg(input logic [2:0] ch, input logic [31:0] inc, input logic [31:0] phase);
    logic rdy;
    int   w;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_phase = phase;
    rdy = cfg_ready;
    w = 0;
    @(negedge clk);
    while (!rdy && w < 100) begin
      rdy = cfg_ready;
      @(negedge clk);
      w++;
    end
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL cfg_accept_timeout: ready never seen, waited %0d cycles, required < 100", w);
    end
    cfg_valid = 1'b0;
    cfg_ch    = 3'($urandom_range(0, 7));
    cfg_inc   = 32'($urandom);
    cfg_phase = 32'($urandom);
  endtask

  task automatic test_reset();
    int k;
    logic [31:0] f;
    reset = 1'b1; en = 4'hF; cfg_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %b required %b", {lock, cfg_ready, cfg_err, ce_out}, 7'b0);
      end
    end
    f = inc_for(50_000_000, 6_250_000);
    n_cmp++;
    if (f !== 32'h2000_0000) begin
      n_bad++;
      $display("FAIL inc_for: got %h required %h", f, 32'h2000_0000);
    end
    reset = 1'b0;
    k = 0;
    while (lock !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_reset @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      if (lock === 1'b0) begin
        n_cmp++;
        if (ce_out !== 4'h0) begin
          n_bad++;
          $display("FAIL strobe_while_unlocked: got %h required 0", ce_out);
        end
      end
    end
    n_cmp++;
    if (k != LOCK_CYCLES) begin
      n_bad++;
      $display("FAIL lock_rise_after_reset: got %0d cycles required %0d", k, LOCK_CYCLES);
    end
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ce_out !== ((t % 8 == 0) ? 4'hF : 4'h0)) begin
        n_bad++;
        $display("FAIL strobe_every_8: t=%0d got %h required %h", t, ce_out, (t % 8 == 0) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_cfg_ch1();
    int last0, first0, low;
    int s1[$];
    last0 = -1; first0 = -1;
    repeat (16) begin
      @(negedge clk);
      if (ce_out[0]) last0 = now_cyc();
    end
    send_cfg(3'd1, 32'h4000_0000, 32'h0);
    low = (lock === 1'b0) ? 1 : 0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_cfg_ch1 @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      if (lock === 1'b0) low++;
      if (ce_out[0] && first0 < 0) first0 = now_cyc();
      if (ce_out[1]) s1.push_back(now_cyc());
    end
    n_cmp++;
    if (low != LOCK_CYCLES + 1) begin
      n_bad++;
      $display("FAIL cfg_lock_low: got %0d cycles required %0d", low, LOCK_CYCLES + 1);
    end
    n_cmp++;
    if (last0 < 0 || first0 <= last0 || (first0 - last0) % 8 != 0) begin
      n_bad++;
      $display("FAIL ch0_phase_kept: gap got %0d required a positive multiple of 8", first0 - last0);
    end
    n_cmp++;
    if (s1.size() < 5) begin
      n_bad++;
      $display("FAIL ch1_strobe_count: got %0d required >= 5", s1.size());
    end
    for (int i = 1; i < s1.size(); i++) begin
      n_cmp++;
      if (s1[i] - s1[i-1] != 4) begin
        n_bad++;
        $display("FAIL ch1_spacing: got %0d required 4", s1[i] - s1[i-1]);
      end
    end
  endtask

  task automatic test_inc_zero_phase();
    int n2, first2;
    n2 = 0; first2 = -1;
    send_cfg(3'd2, 32'h0, 32'($urandom));
    repeat (1000) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_inc_zero @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      if (ce_out[2]) n2++;
    end
    n_cmp++;
    if (n2 != 0) begin
      n_bad++;
      $display("FAIL ch2_inc_zero: got %0d strobes required 0", n2);
    end
    send_cfg(3'd2, 32'h2000_0000, 32'hE000_0000);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_phase_load @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      if (ce_out[2] && first2 < 0) first2 = t;
    end
    n_cmp++;
    if (first2 != 18) begin
      n_bad++;
      $display("FAIL ch2_phase_first_strobe: got t=%0d required t=18", first2);
    end
  endtask

  task automatic test_bad_ch();
    send_cfg(3'd5, 32'($urandom), 32'($urandom));
    n_cmp++;
    if ({cfg_err, lock, cfg_ready} !== 3'b110) begin
      n_bad++;
      $display("FAIL bad_ch_apply: err/lock/rdy got %b required 110", {cfg_err, lock, cfg_ready});
    end
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_bad_ch @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      n_cmp++;
      if ({lock, cfg_ready, cfg_err} !== 3'b110) begin
        n_bad++;
        $display("FAIL bad_ch_after: t=%0d lock/rdy/err got %b required 110", t, {lock, cfg_ready, cfg_err});
      end
    end
  endtask

  task automatic test_en_pause();
    int w, first3;
    w = 0; first3 = -1;
    while (ce_out[3] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (ce_out[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL ch3_strobe_seen: got %b required 1 within 20 cycles", ce_out[3]);
    end
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_en_pause @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      if (ce_out[3] && first3 < 0) first3 = t;
      if (t == 3) en[3] = 1'b0;
      if (t == 8) en[3] = 1'b1;
    end
    n_cmp++;
    if (first3 != 13) begin
      n_bad++;
      $display("FAIL ch3_pause_delay: got t=%0d required t=13", first3);
    end
  endtask

  task automatic test_full_inc();
    int w, n0;
    w = 0; n0 = 0;
    send_cfg(3'd0, 32'hFFFF_FFFF, 32'h0);
    while (lock !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    repeat (50) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_full_inc @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      if (ce_out[0]) n0++;
    end
    n_cmp++;
    if (n0 != 50) begin
      n_bad++;
      $display("FAIL ch0_full_inc: got %0d strobes required 50", n0);
    end
  endtask

  task automatic test_random();
    logic prev_rdy;
    int   b;
    prev_rdy = cfg_ready;
    repeat (3000) begin
      @(negedge clk);
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_random @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
      reset = ($urandom_range(0, 599) == 0);
      if (cfg_valid && prev_rdy && !reset) begin
        cfg_valid = 1'b0;
        cfg_ch    = 3'($urandom_range(0, 7));
        cfg_inc   = 32'($urandom);
        cfg_phase = 32'($urandom);
      end else if (!cfg_valid && $urandom_range(0, 39) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
          0:       cfg_inc = 32'($urandom);
          1:       cfg_inc = 32'($urandom) >> $urandom_range(1, 8);
          2:       cfg_inc = 32'h0;
          3:       cfg_inc = 32'hFFFF_FFFF;
          default: cfg_inc = 32'h1 << $urandom_range(26, 31);
        endcase
        cfg_phase = 32'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, 3);
        en[b] = ~en[b];
      end
      prev_rdy = cfg_ready;
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_relock();
    int w, k;
    en = 4'hF; cfg_valid = 1'b0; reset = 1'b0;
    w = 0;
    while (cfg_ready !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    send_cfg(3'd1, 32'($urandom), 32'($urandom));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (lock !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      n_cmp++;
      if ({lock, cfg_ready, cfg_err, ce_out} !== {m_lock, m_ready, m_err, m_ce}) begin
        n_bad++;
        $display("FAIL model_relock @%0t: got %b required %b", $time,
                 {lock, cfg_ready, cfg_err, ce_out}, {m_lock, m_ready, m_err, m_ce});
      end
    end
    n_cmp++;
    if (k != LOCK_CYCLES) begin
      n_bad++;
      $display("FAIL relock_cycles: got %0d required %0d", k, LOCK_CYCLES);
    end
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ce_out !== ((t % 8 == 0) ? 4'hF : 4'h0)) begin
        n_bad++;
        $display("FAIL relock_default_inc: t=%0d got %h required %h", t, ce_out, (t % 8 == 0) ? 4'hF : 4'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cfg_ch1();
    test_inc_zero_phase();
    test_bad_ch();
    test_en_pause();
    test_full_inc();
    test_random();
    test_reset_relock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
